// File: rtl/stack_unit.sv
// LIFO operand stack beside the datapath: push/pop/peek strobes from the controller,
// registered read data, occupancy and sticky overflow/underflow flags.
module stack_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       tos,
  input  logic [WIDTH-1:0]           d_in,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           d_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [CW-1:0]    sp_nxt;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] top_val;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             dout_ld;
  logic [WIDTH-1:0] dout_nxt;
  logic             ovf_set;
  logic             unf_set;

  assign count   = sp;
  assign full    = (sp == CW'(DEPTH));
  assign empty   = (sp == CW'(0));
  assign top_idx = AW'(sp - CW'(1));
  assign wr_idx  = AW'(sp);
  assign top_val = mem[top_idx];

  // Command decode; illegal operations are suppressed so sp saturates at 0 and DEPTH.
  always_comb begin
    sp_nxt   = sp;
    wr_en    = 1'b0;
    wr_addr  = wr_idx;
    dout_ld  = 1'b0;
    dout_nxt = d_out;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (push && pop) begin
      if (!empty) begin
        wr_en    = 1'b1;
        wr_addr  = top_idx;
        dout_ld  = 1'b1;
        dout_nxt = top_val;
      end else begin
        wr_en   = 1'b1;
        sp_nxt  = sp + CW'(1);
        unf_set = 1'b1;
      end
    end else if (push) begin
      if (!full) begin
        wr_en  = 1'b1;
        sp_nxt = sp + CW'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end else if (pop || tos) begin
      dout_ld = 1'b1;
      if (!empty) begin
        dout_nxt = top_val;
        if (pop) sp_nxt = sp - CW'(1);
      end else begin
        dout_nxt = '0;
        unf_set  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp    <= '0;
      d_out <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      sp  <= sp_nxt;
      ovf <= ovf_set | (ovf & ~clr_err);
      unf <= unf_set | (unf & ~clr_err);
      if (dout_ld) d_out <= dout_nxt;
    end
  end

  // Storage array is deliberately not reset; it is unobservable while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= d_in;
  end

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: driver queues the expected post-edge state,
// monitor pops and compares shortly after each rising edge.
module tb_stack_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       push, pop, tos, clr_err;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic [3:0] count;
  logic       full, empty, ovf, unf;

  typedef struct {
    string      name;
    logic [7:0] dout;
    logic [3:0] cnt;
    logic       fl;
    logic       em;
    logic       o;
    logic       u;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  stack_unit #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .d_in(d_in),
    .clr_err(clr_err), .d_out(d_out), .count(count), .full(full),
    .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Monitor: every rising edge presents a new state; compare against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (d_out !== e.dout || count !== e.cnt || full !== e.fl || empty !== e.em ||
          ovf !== e.o || unf !== e.u) begin
        bad++;
        $display("FAIL %s: got d_out=%h count=%0d full=%b empty=%b ovf=%b unf=%b, want d_out=%h count=%0d full=%b empty=%b ovf=%b unf=%b",
                 e.name, d_out, count, full, empty, ovf, unf,
                 e.dout, e.cnt, e.fl, e.em, e.o, e.u);
      end
    end
  end

  task automatic step(input string nm, input logic p, input logic po, input logic t,
                      input logic c, input logic [7:0] d,
                      input logic [7:0] ed, input int ec, input logic eo, input logic eu);
    exp_t e;
    push = p; pop = po; tos = t; clr_err = c; d_in = d;
    e.name = nm; e.dout = ed; e.cnt = 4'(ec);
    e.fl = (ec == 8); e.em = (ec == 0); e.o = eo; e.u = eu;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; push = 0; pop = 0; tos = 0; clr_err = 0; d_in = '0;
    @(negedge clk);
    // Reset held with random strobes
    for (int i = 0; i < 4; i++)
      step("reset_hold", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 8'h00, 0, 0, 0);
    rst = 1'b1;
    step("reset_rel", 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    // LIFO order
    step("push11", 1, 0, 0, 0, 8'h11, 8'h00, 1, 0, 0);
    step("push22", 1, 0, 0, 0, 8'h22, 8'h00, 2, 0, 0);
    step("push33", 1, 0, 0, 0, 8'h33, 8'h00, 3, 0, 0);
    step("pop33",  0, 1, 0, 0, 8'h00, 8'h33, 2, 0, 0);
    step("pop22",  0, 1, 0, 0, 8'h00, 8'h22, 1, 0, 0);
    step("pop11",  0, 1, 0, 0, 8'h00, 8'h11, 0, 0, 0);

    // Peek
    step("push5a", 1, 0, 0, 0, 8'h5A, 8'h11, 1, 0, 0);
    step("tos1",   0, 0, 1, 0, 8'h00, 8'h5A, 1, 0, 0);
    step("tos2",   0, 0, 1, 0, 8'h00, 8'h5A, 1, 0, 0);
    step("pop5a",  0, 1, 0, 0, 8'h00, 8'h5A, 0, 0, 0);

    // Fill, overflow, drain
    for (int i = 1; i <= 8; i++)
      step("fill", 1, 0, 0, 0, 8'(i), 8'h5A, i, 0, 0);
    step("push_full", 1, 0, 0, 0, 8'hFF, 8'h5A, 8, 1, 0);
    for (int i = 8; i >= 1; i--)
      step("drain", 0, 1, 0, 0, 8'h00, 8'(i), i - 1, 1, 0);
    step("clr_ovf", 0, 0, 0, 1, 8'h00, 8'h01, 0, 0, 0);

    // Underflow and flag priority
    step("pop_empty",   0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    step("clr_unf",     0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    step("clr_tos_emp", 0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 1);
    step("clr_unf2",    0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);

    // Replace top
    step("push10",  1, 0, 0, 0, 8'h10, 8'h00, 1, 0, 0);
    step("push20",  1, 0, 0, 0, 8'h20, 8'h00, 2, 0, 0);
    step("replace", 1, 1, 0, 0, 8'h99, 8'h20, 2, 0, 0);
    step("pop99",   0, 1, 0, 0, 8'h00, 8'h99, 1, 0, 0);
    step("pop10",   0, 1, 0, 0, 8'h00, 8'h10, 0, 0, 0);

    // push&pop on empty behaves as push and flags underflow; tos ignored with push
    step("pp_empty",  1, 1, 0, 0, 8'h77, 8'h10, 1, 0, 1);
    step("push_tos",  1, 0, 1, 0, 8'h44, 8'h10, 2, 0, 1);
    step("pop44",     0, 1, 0, 0, 8'h00, 8'h44, 1, 0, 1);
    step("pop77",     0, 1, 0, 0, 8'h00, 8'h77, 0, 0, 1);

    // Reset mid-operation discards the command
    step("push_ab", 1, 0, 0, 0, 8'hAB, 8'h77, 1, 0, 1);
    rst = 1'b0;
    step("rst_mid", 1, 0, 0, 0, 8'hCD, 8'h00, 0, 0, 0);
    rst = 1'b1;
    step("tos_after_rst", 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1);

    push = 0; pop = 0; tos = 0; clr_err = 0;
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware LIFO operand stack for the stack-based multicycle processor. It sits directly beside the Datapath and is driven each cycle by the Controller's `push`, `pop` and `tos` strobes. It accepts write data from the datapath's StackSrc mux and returns the popped or peeked operand in a register that feeds the A/B operand registers. It also tracks occupancy and flags overflow and underflow so stack faults are visible during simulation.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `DEPTH`, default 8: number of stack entries, at least 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low (0 = reset).
- `push`  in  1  push `d_in` this cycle.
- `pop`  in  1  pop top entry into `d_out` this cycle.
- `tos`  in  1  peek top entry into `d_out` without removing it.
- `d_in`  in  WIDTH  data to push.
- `clr_err`  in  1  synchronous clear of the sticky `ovf`/`unf` flags.
- `d_out`  out  WIDTH  registered read data.
- `count`  out  $clog2(DEPTH+1)  current number of valid entries.
- `full`  out  1  `count == DEPTH`, combinational from `count`.
- `empty`  out  1  `count == 0`, combinational from `count`.
- `ovf`  out  1  sticky flag: push attempted while full.
- `unf`  out  1  sticky flag: pop or tos attempted while empty.

## Operation
- Storage is a DEPTH x WIDTH register array. The internal pointer `sp` equals `count` and indexes the next free slot, so the top entry is `mem[sp-1]`.
- The command is decoded each rising edge in the priority order below. At most one case applies.
  - `push & pop`, not empty: replace the top. `d_out <= mem[sp-1]` (old value), then `mem[sp-1] <= d_in`. `sp` is unchanged.
  - `push & pop`, empty: executes as a plain push. `unf` is set.
  - `push`, not full: `mem[sp] <= d_in`, `sp <= sp+1`. `d_out` is unchanged.
  - `push`, full: no write and no pointer change. `ovf` is set and `d_out` is unchanged.
  - `pop`, not empty: `d_out <= mem[sp-1]`, `sp <= sp-1`.
  - `pop`, empty: `d_out <= 0`, `sp` is unchanged, `unf` is set.
  - `tos`, not empty: `d_out <= mem[sp-1]`. `sp` is unchanged.
  - `tos`, empty: `d_out <= 0`, `unf` is set.
  - No strobe: everything holds.
- `tos` is ignored whenever `push` or `pop` is asserted.
- `sp` never wraps. It saturates at 0 and at DEPTH because illegal operations are suppressed.
- Flags:
  - `clr_err` clears `ovf` and `unf` on the edge.
  - If a new error occurs in the same cycle as `clr_err`, the corresponding flag is set (set wins).
  - Flags have no effect on operation.

## Timing
- Reset (`rst` = 0, asynchronous, immediate): `sp` = 0, `d_out` = 0, `ovf` = `unf` = 0. As a result `count` = 0, `empty` = 1 and `full` = 0.
- The array contents are not reset. They cannot be observed while empty.
- Reset asserted mid-operation discards any in-flight command. The first edge after `rst` rises operates on an empty stack.
- Read latency is 1 cycle. `d_out` is valid after the edge that sampled `pop`/`tos` and holds until the next pop, tos, replace or reset.
- A push is visible to a `tos` or `pop` on the very next edge, with no bubble.
- `count`, `full` and `empty` update on the same edge as `sp`.
- There is no handshake. The Controller must not rely on `full`/`empty` combinationally within the same state that issues the strobe.

## Test plan
- Reset check: hold `rst` = 0 with random strobes, then release. Required: `d_out` = 0, `count` = 0, `empty` = 1, `ovf` = `unf` = 0.
- Push/pop LIFO order: push 0x11, 0x22, 0x33, then pop three times. Required: `d_out` = 0x33, 0x22, 0x11 on successive cycles; `count` goes 3, 2, 1, 0; `empty` returns to 1.
- Peek: push 0x5A, then assert `tos` twice. Required: `d_out` = 0x5A both times and `count` stays 1.
- Full and overflow (DEPTH = 8): push 0x01 through 0x08. Required: `full` = 1. A ninth push of 0xFF leaves `count` = 8 and sets `ovf` = 1. A subsequent pop returns 0x08, not 0xFF.
- Underflow and flag priority:
  - Pop on an empty stack: required `d_out` = 0 and `unf` = 1.
  - `clr_err` alone: required `unf` = 0.
  - `clr_err` together with `tos` on empty: required `unf` = 1 (set wins).
- Replace top: push 0x10, 0x20, then assert `push & pop` with `d_in` = 0x99. Required: `d_out` = 0x20 and `count` = 2. The next pop returns 0x99.
